// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the register file: clears registers 1..N-1 after reset,
// then round-robin arbitrates the ALU and load-unit write-back requesters.
module regfile_write_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [WIDTH-1:0]     req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [WIDTH-1:0]     req1_data,
  output logic                 req1_ready,
  output logic                 wr_enable,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [WIDTH-1:0]     wr_data,
  output logic                 grant_id,
  output logic                 init_busy
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_BITS-1:0] ONE_ADDR  = ADDR_BITS'(1);

  state_t               state, state_d;
  logic [ADDR_BITS-1:0] cnt, cnt_d;
  logic                 last_grant, last_grant_d;
  logic                 grant_valid, grant_sel;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [WIDTH-1:0]     sel_data;
  logic                 wr_enable_d;
  logic [ADDR_BITS-1:0] wr_addr_d;
  logic [WIDTH-1:0]     wr_data_d;
  logic                 grant_id_d;
  logic                 init_busy_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_d;
  end

  // Next state: leave the clear sequence once the last register is issued
  always_comb begin
    state_d = state;
    if (state == ST_INIT && cnt == LAST_ADDR) state_d = ST_RUN;
  end

  // Grant, handshakes and next values of the registered write port
  always_comb begin
    grant_valid  = 1'b0;
    grant_sel    = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    sel_addr     = req0_addr;
    sel_data     = req0_data;
    cnt_d        = cnt;
    last_grant_d = last_grant;
    wr_enable_d  = 1'b0;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    grant_id_d   = grant_id;
    init_busy_d  = init_busy;

    if (state == ST_INIT) begin
      wr_enable_d = 1'b1;
      wr_addr_d   = cnt;
      wr_data_d   = '0;
      cnt_d       = cnt + ONE_ADDR;
      if (cnt == LAST_ADDR) init_busy_d = 1'b0;
    end else begin
      // On contention the requester that did not win last time goes first
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_sel   = ~last_grant;
      end else if (req0_valid || req1_valid) begin
        grant_valid = 1'b1;
        grant_sel   = req1_valid;
      end
      req0_ready = grant_valid && !grant_sel;
      req1_ready = grant_valid && grant_sel;

      if (grant_valid) begin
        sel_addr     = grant_sel ? req1_addr : req0_addr;
        sel_data     = grant_sel ? req1_data : req0_data;
        wr_addr_d    = sel_addr;
        wr_data_d    = sel_data;
        grant_id_d   = grant_sel;
        last_grant_d = grant_sel;
        // Register 0 is hardwired: consume the transfer but do not write
        wr_enable_d  = (sel_addr != '0);
      end
    end
  end

  // Registered write port and arbitration history
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= ONE_ADDR;
      last_grant <= 1'b1;
      wr_enable  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      grant_id   <= 1'b0;
      init_busy  <= 1'b1;
    end else begin
      cnt        <= cnt_d;
      last_grant <= last_grant_d;
      wr_enable  <= wr_enable_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      grant_id   <= grant_id_d;
      init_busy  <= init_busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a reference model predicts handshakes
// and register-file writes; a separate monitor checks every write the DUT presents.
module tb_regfile_write_arbiter;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned ADDR_BITS = 5;
  localparam int          NREGS     = 32;

  typedef struct {
    logic [ADDR_BITS-1:0] addr;
    logic [WIDTH-1:0]     data;
    logic                 gid;
  } wr_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req0_valid, req1_valid;
  logic [ADDR_BITS-1:0] req0_addr, req1_addr;
  logic [WIDTH-1:0]     req0_data, req1_data;
  logic                 req0_ready, req1_ready;
  logic                 wr_enable;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic                 grant_id;
  logic                 init_busy;

  int n_checks = 0;
  int n_err    = 0;

  wr_t sb[$];
  wr_t mon_e;
  bit  mon_armed = 1'b0;

  // Reference model state: what the write port should be doing, in plain terms
  bit  m_known   = 1'b0;
  bit  m_running = 1'b0;
  int  m_next    = 1;
  int  m_tie     = 0;
  bit  m_exp_en  = 1'b0;
  bit  m_exp_gid = 1'b0;

  regfile_write_arbiter #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .grant_id(grant_id), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  // Reference model: predicts this cycle's handshakes and the effect of the next edge
  always @(negedge clk) begin
    int  w;
    wr_t e;
    w = -1;
    if (m_known && m_running) begin
      if (req0_valid && req1_valid) w = m_tie;
      else if (req0_valid)          w = 0;
      else if (req1_valid)          w = 1;
    end
    if (m_known) begin
      chk("req0_ready", 32'(req0_ready), 32'(w == 0));
      chk("req1_ready", 32'(req1_ready), 32'(w == 1));
      chk("init_busy",  32'(init_busy),  32'(!m_running));
      chk("wr_enable",  32'(wr_enable),  32'(m_exp_en));
      chk("grant_id_hold", 32'(grant_id), 32'(m_exp_gid));
    end
    if (reset) begin
      m_known   = 1'b1;
      m_running = 1'b0;
      m_next    = 1;
      m_tie     = 0;
      m_exp_en  = 1'b0;
      m_exp_gid = 1'b0;
    end else if (m_known) begin
      if (!m_running) begin
        e.addr = ADDR_BITS'(m_next);
        e.data = '0;
        e.gid  = 1'b0;
        sb.push_back(e);
        m_exp_en = 1'b1;
        m_next++;
        if (m_next == NREGS) m_running = 1'b1;
      end else if (w >= 0) begin
        e.addr = (w == 1) ? req1_addr : req0_addr;
        e.data = (w == 1) ? req1_data : req0_data;
        e.gid  = (w == 1);
        m_tie     = 1 - w;
        m_exp_gid = (w == 1);
        m_exp_en  = (e.addr != 0);
        if (e.addr != 0) sb.push_back(e);
      end else begin
        m_exp_en = 1'b0;
      end
    end
  end

  // Monitor: every write the DUT presents must match the oldest predicted write
  always @(negedge clk) begin
    if (!mon_armed) begin
      if (reset === 1'b1) mon_armed = 1'b1;
    end else if (wr_enable === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_write at %0t: got addr %0d data %h, required no write",
                 $time, wr_addr, wr_data);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr",  32'(wr_addr),  32'(mon_e.addr));
        chk("wr_data",  wr_data,       mon_e.data);
        chk("grant_id", 32'(grant_id), 32'(mon_e.gid));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold one request until accepted (bounded), then drop valid
  task automatic send(input int id, input logic [ADDR_BITS-1:0] a, input logic [WIDTH-1:0] d);
    bit got;
    got = 1'b0;
    if (id == 0) begin req0_valid = 1'b1; req0_addr = a; req0_data = d; end
    else         begin req1_valid = 1'b1; req1_addr = a; req1_data = d; end
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      got = (id == 0) ? req0_ready : req1_ready;
      tick();
    end
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: requester %0d never accepted, required acceptance", id);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc0, acc1, found;
    reset = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

    // Clear sequence with no requesters
    tick();
    reset = 1'b0;
    repeat (36) tick();

    // Request held across reset, accepted on the first RUN cycle
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEADBEEF;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send(0, 5'd3, 32'hDEADBEEF);
    repeat (2) tick();

    // Write to register 0 is consumed without a write
    send(1, 5'd0, 32'hFFFFFFFF);
    repeat (2) tick();

    // Both requesters continuously: alternate grants
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hA;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'hB;
    repeat (8) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) tick();

    // Back-to-back writes from requester 1 alone
    for (int a = 7; a <= 10; a++) send(1, ADDR_BITS'(a), 32'h1000 + 32'(a));
    repeat (2) tick();

    // Reset during the clear, in the cycle writing register 10
    reset = 1'b1;
    tick();
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = (wr_enable === 1'b1 && wr_addr == 5'd9);
    end
    if (!found) begin
      n_checks++;
      n_err++;
      $display("FAIL init_addr9_timeout: never saw wr_addr 9, required it");
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (36) tick();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      tick();
      reset = ($urandom_range(0, 149) == 0);
      if (!(req0_valid && !acc0 && $urandom_range(0, 7) != 0)) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_addr  = ADDR_BITS'($urandom);
        req0_data  = $urandom;
      end
      if (!(req1_valid && !acc1 && $urandom_range(0, 7) != 0)) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_addr  = ADDR_BITS'($urandom);
        req1_data  = $urandom;
      end
    end
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (40) tick();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
